phase_seq_fsm: RTL and testbench

Parametrised successor to the team's three-state IDLE/LOAD/DONE controller. It adds a configurable LOAD duration, a per-job RUN phase whose length is captured at start, abort, optional back-to-back restart, and handshake and status outputs. It sits between a job-issuing master and a datapath that needs a load window followed by a counted run window.

---
 rtl/phase_seq_pkg.sv | 10 +
 rtl/phase_seq_fsm_if.sv | 17 +
 rtl/phase_counter.sv | 20 ++
 rtl/phase_seq_fsm.sv | 56 +++++
 tb/tb_phase_seq_fsm.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/phase_seq_pkg.sv
// phase_seq_pkg: state encoding shared by the phase sequencer, its interface and bench
//   exports state_t with ST_IDLE=00, ST_LOAD=01, ST_RUN=10, ST_DONE=11
package phase_seq_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;
endpackage

// File: rtl/phase_seq_fsm_if.sv
// phase_seq_fsm_if: job handshake and status bundle between issuer and sequencer
//   master drives start, abort, len
//   slave drives state, busy, start_ack, done, aborted, count
interface phase_seq_fsm_if #(parameter int CNT_W = 8);
    import phase_seq_pkg::*;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] len;
    state_t           state;
    logic             busy;
    logic             start_ack;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] count;
    modport master (output start, abort, len, input state, busy, start_ack, done, aborted, count);
    modport slave (input start, abort, len, output state, busy, start_ack, done, aborted, count);
endinterface

// File: rtl/phase_counter.sv
// phase_counter: shared cycle counter for the LOAD and RUN phases
//   clk, reset: clock and synchronous active-high reset
//   clear: zero the count on the next edge (wins over enable)
//   enable: advance the count by one
//   term: terminal count value; hit: count equals term
//   count: registered cycle index
module phase_counter #(parameter int CNT_W = 8) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] term,
    output logic             hit,
    output logic [CNT_W-1:0] count
);
    assign hit = count == term;
    always_ff @(posedge clk)
        if (reset || clear) count <= '0;
        else if (enable) count <= count + CNT_W'(1);
endmodule

// File: rtl/phase_seq_fsm.sv
// phase_seq_fsm: job sequencer running a fixed LOAD window then a per-job counted RUN window
//   clk, reset: clock and synchronous active-high reset
//   bus (slave): start/abort/len in; state/busy/start_ack/done/aborted/count out, all registered
module phase_seq_fsm
    import phase_seq_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int LOAD_CYCLES  = 2,
    parameter bit AUTO_RESTART = 1'b0
) (
    input logic            clk,
    input logic            reset,
    phase_seq_fsm_if.slave bus
);
    localparam logic [CNT_W-1:0] LOAD_TERM = CNT_W'(LOAD_CYCLES - 1);
    state_t           state_q, nxt;
    logic [CNT_W-1:0] len_q;
    logic             hit, in_phase, entry;
    assign in_phase = state_q == ST_LOAD || state_q == ST_RUN;
    assign entry    = nxt == ST_LOAD && state_q != ST_LOAD;
    assign bus.state = state_q;
    always_comb
        unique case (state_q)
            ST_IDLE: nxt = bus.start ? ST_LOAD : ST_IDLE;
            ST_LOAD: nxt = bus.abort ? ST_IDLE : !hit ? ST_LOAD : len_q != '0 ? ST_RUN : ST_DONE;
            ST_RUN:  nxt = bus.abort ? ST_IDLE : hit ? ST_DONE : ST_RUN;
            default: nxt = AUTO_RESTART && bus.start ? ST_LOAD : ST_IDLE;
        endcase
    // Any state change restarts the index, so every phase counts from 0 and
    // IDLE/DONE hold 0. In RUN len_q is nonzero, so len_q-1 never underflows.
    phase_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (nxt != state_q),
        .enable (in_phase),
        .term   (state_q == ST_LOAD ? LOAD_TERM : len_q - CNT_W'(1)),
        .hit    (hit),
        .count  (bus.count)
    );
    always_ff @(posedge clk)
        if (reset) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            bus.busy      <= 1'b0;
            bus.start_ack <= 1'b0;
            bus.done      <= 1'b0;
            bus.aborted   <= 1'b0;
        end else begin
            state_q       <= nxt;
            bus.busy      <= nxt == ST_LOAD || nxt == ST_RUN;
            bus.start_ack <= entry;
            bus.done      <= nxt == ST_DONE;
            bus.aborted   <= in_phase && bus.abort;
            if (entry) len_q <= bus.len;
        end
endmodule

// File: tb/tb_phase_seq_fsm.sv
// tb_phase_seq_fsm: random and directed stimulus on two sequencer configurations against a timeline model
module tb_phase_seq_fsm;
    localparam int W = 8;
    logic clk = 1'b0;
    logic reset, start, abort;
    logic [W-1:0] len;
    int n = 0, errs = 0, cyc = 0;
    int lc [2] = '{2, 3};
    bit ar [2] = '{1'b0, 1'b1};
    bit in_job [2] = '{1'b0, 1'b0};
    bit ab [2] = '{1'b0, 1'b0};
    int el [2] = '{0, 0};
    int jl [2] = '{0, 0};

    always #5 clk = ~clk;

    phase_seq_fsm_if #(.CNT_W(W)) bus0 ();
    phase_seq_fsm_if #(.CNT_W(W)) bus1 ();
    assign bus0.start = start;
    assign bus0.abort = abort;
    assign bus0.len   = len;
    assign bus1.start = start;
    assign bus1.abort = abort;
    assign bus1.len   = len;

    phase_seq_fsm #(.CNT_W(W), .LOAD_CYCLES(2), .AUTO_RESTART(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    phase_seq_fsm #(.CNT_W(W), .LOAD_CYCLES(3), .AUTO_RESTART(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // Expected outputs from elapsed time since LOAD entry: [0,L) LOAD, [L,L+len) RUN, L+len DONE.
    function automatic logic [W+5:0] expv(int i);
        logic [1:0] st;
        logic [W-1:0] c;
        st = 2'd0;
        c = '0;
        if (in_job[i]) begin
            if (el[i] < lc[i]) begin st = 2'd1; c = W'(el[i]); end
            else if (el[i] < lc[i] + jl[i]) begin st = 2'd2; c = W'(el[i] - lc[i]); end
            else st = 2'd3;
        end
        return {st, st == 2'd1 || st == 2'd2, in_job[i] && el[i] == 0, st == 2'd3, ab[i], c};
    endfunction

    function automatic logic [W+5:0] act(int i);
        return i == 0 ? {bus0.state, bus0.busy, bus0.start_ack, bus0.done, bus0.aborted, bus0.count}
                      : {bus1.state, bus1.busy, bus1.start_ack, bus1.done, bus1.aborted, bus1.count};
    endfunction

    task automatic step(input logic s, input logic a, input logic [W-1:0] l, input logic r);
        start = s;
        abort = a;
        len = l;
        reset = r;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                in_job[i] = 1'b0;
                ab[i] = 1'b0;
            end else begin
                ab[i] = 1'b0;
                if (in_job[i] && el[i] < lc[i] + jl[i]) begin
                    if (a) begin in_job[i] = 1'b0; ab[i] = 1'b1; end
                    else el[i]++;
                end else if (in_job[i]) begin
                    if (ar[i] && s) begin el[i] = 0; jl[i] = int'(l); end
                    else in_job[i] = 1'b0;
                end else if (s) begin
                    in_job[i] = 1'b1;
                    el[i] = 0;
                    jl[i] = int'(l);
                end
            end
        end
        #1;
    endtask

    task automatic settle(input int k);
        for (int j = 0; j < k; j++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 8'd3, 1'b1);
            for (int i = 0; i < 2; i++) begin
                n++;
                if (act(i) !== '0) begin errs++; $display("FAIL reset dut%0d t=%0t got %h want 0", i, $time, act(i)); end
            end
        end
        step(1'b1, 1'b0, 8'd3, 1'b0);
        n++;
        if (bus0.state !== 2'b01 || bus0.start_ack !== 1'b1)
            begin errs++; $display("FAIL reset_release state=%b ack=%b want 01/1", bus0.state, bus0.start_ack); end
        for (int i = 0; i < 2; i++) begin
            n++;
            if (act(i) !== expv(i)) begin errs++; $display("FAIL reset_release dut%0d got %h want %h", i, act(i), expv(i)); end
        end
        settle(20);
    endtask

    task automatic test_basic();
        logic [1:0] es [7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        int ec [7] = '{0, 1, 0, 1, 2, 0, 0};
        step(1'b1, 1'b0, 8'd3, 1'b0);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step(1'b0, 1'b0, 8'd9, 1'b0);
            n++;
            if (bus0.state !== es[k] || bus0.count !== W'(ec[k]) || bus0.done !== (k == 5))
                begin errs++; $display("FAIL basic_trace T+%0d got st=%b cnt=%0d done=%b want st=%b cnt=%0d done=%b",
                    k + 1, bus0.state, bus0.count, bus0.done, es[k], ec[k], k == 5); end
            for (int i = 0; i < 2; i++) begin
                n++;
                if (act(i) !== expv(i)) begin errs++; $display("FAIL basic dut%0d t=%0t got %h want %h", i, $time, act(i), expv(i)); end
            end
        end
        settle(10);
    endtask

    task automatic test_len0();
        bit saw_run = 1'b0;
        step(1'b1, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step(1'b0, 1'b0, 8'd0, 1'b0);
            if (bus0.state == 2'b10 || bus1.state == 2'b10) saw_run = 1'b1;
            for (int i = 0; i < 2; i++) begin
                n++;
                if (act(i) !== expv(i)) begin errs++; $display("FAIL len0 dut%0d t=%0t got %h want %h", i, $time, act(i), expv(i)); end
            end
        end
        n++;
        if (saw_run !== 1'b0) begin errs++; $display("FAIL len0_no_run saw_run=%b want 0", saw_run); end
        settle(5);
    endtask

    task automatic test_abort();
        bit saw_done = 1'b0;
        step(1'b1, 1'b0, 8'd5, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'd5, 1'b0);
        n++;
        if (bus0.state !== 2'b10 || bus0.count !== 8'd1)
            begin errs++; $display("FAIL abort_setup st=%b cnt=%0d want 10/1", bus0.state, bus0.count); end
        step(1'b1, 1'b1, 8'd5, 1'b0);
        n++;
        if (bus0.state !== 2'b00 || bus0.aborted !== 1'b1 || bus0.start_ack !== 1'b0)
            begin errs++; $display("FAIL abort st=%b aborted=%b ack=%b want 00/1/0", bus0.state, bus0.aborted, bus0.start_ack); end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step(1'b0, 1'b0, 8'd5, 1'b0);
            if (bus0.done) saw_done = 1'b1;
            for (int i = 0; i < 2; i++) begin
                n++;
                if (act(i) !== expv(i)) begin errs++; $display("FAIL abort dut%0d t=%0t got %h want %h", i, $time, act(i), expv(i)); end
            end
        end
        n++;
        if (saw_done !== 1'b0) begin errs++; $display("FAIL abort_no_done saw_done=%b want 0", saw_done); end
    endtask

    task automatic test_start_ignored();
        step(1'b1, 1'b0, 8'd4, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'($urandom_range(0, 1)), 1'b0, W'($urandom_range(0, 9)), 1'b0);
            for (int i = 0; i < 2; i++) begin
                n++;
                if (act(i) !== expv(i)) begin errs++; $display("FAIL start_ignored dut%0d t=%0t got %h want %h", i, $time, act(i), expv(i)); end
            end
        end
        settle(20);
    endtask

    task automatic test_back_to_back();
        int last_ack = -1, ack_len = 0;
        logic [W-1:0] l;
        for (int k = 0; k < 60; k++) begin
            l = W'($urandom_range(0, 6));
            step(1'b1, 1'b0, l, 1'b0);
            if (bus1.start_ack === 1'b1) begin
                if (last_ack >= 0) begin
                    n++;
                    if (cyc - last_ack != 3 + ack_len + 1)
                        begin errs++; $display("FAIL b2b_period got %0d want %0d", cyc - last_ack, 3 + ack_len + 1); end
                end
                last_ack = cyc;
                ack_len = int'(l);
            end
            for (int i = 0; i < 2; i++) begin
                n++;
                if (act(i) !== expv(i)) begin errs++; $display("FAIL b2b dut%0d t=%0t got %h want %h", i, $time, act(i), expv(i)); end
            end
        end
        settle(20);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 8'd3, 1'b0);
        step(1'b0, 1'b0, 8'd3, 1'b0);
        step(1'b0, 1'b0, 8'd3, 1'b1);
        for (int k = 0; k < 2; k++) begin
            if (k > 0) step(1'b0, 1'b0, 8'd3, 1'b0);
            for (int i = 0; i < 2; i++) begin
                n++;
                if (act(i) !== '0) begin errs++; $display("FAIL reset_mid dut%0d t=%0t got %h want 0", i, $time, act(i)); end
            end
        end
        step(1'b1, 1'b0, 8'd2, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step(1'b0, 1'b0, 8'd7, 1'b0);
            for (int i = 0; i < 2; i++) begin
                n++;
                if (act(i) !== expv(i)) begin errs++; $display("FAIL reset_mid_job dut%0d t=%0t got %h want %h", i, $time, act(i), expv(i)); end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] l;
        for (int k = 0; k < 600; k++) begin
            l = $urandom_range(0, 19) == 0 ? W'($urandom_range(200, 255)) : W'($urandom_range(0, 9));
            step(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, l, $urandom_range(0, 49) == 0);
            for (int i = 0; i < 2; i++) begin
                n++;
                if (act(i) !== expv(i)) begin errs++; $display("FAIL random dut%0d t=%0t got %h want %h", i, $time, act(i), expv(i)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
        $finish;
    end
endmodule
